// File: rtl/cba_readout_arbiter_if.sv
// Bus bundle between the core-column adapters, the readout arbiter and the
// downstream formatter: per-requester hit words in, one tagged stream out.
interface cba_readout_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int ROW_BITS  = 10,
  parameter int DATA_BITS = 16
);
  localparam int SRC_BITS = $clog2(NREQ);

  logic [NREQ-1:0]           in_valid;
  logic [NREQ*ROW_BITS-1:0]  in_row_id;
  logic [NREQ*DATA_BITS-1:0] in_data;
  logic [NREQ-1:0]           busy_in;
  logic                      start;
  logic                      clear_ovf;
  logic                      out_valid;
  logic                      out_ready;
  logic [ROW_BITS-1:0]       out_row_id;
  logic [DATA_BITS-1:0]      out_data;
  logic [SRC_BITS-1:0]       out_src;
  logic [NREQ-1:0]           hold_out;
  logic [NREQ-1:0]           overflow;
  logic                      active;
  logic                      done;
  logic [15:0]               word_count;

  modport master (
    output in_valid, in_row_id, in_data, busy_in, start, clear_ovf, out_ready,
    input  out_valid, out_row_id, out_data, out_src, hold_out, overflow,
           active, done, word_count
  );

  modport slave (
    input  in_valid, in_row_id, in_data, busy_in, start, clear_ovf, out_ready,
    output out_valid, out_row_id, out_data, out_src, hold_out, overflow,
           active, done, word_count
  );
endinterface

// File: rtl/cba_readout_arbiter.sv
// Round-robin merge of NREQ adapter hit streams through 2-deep per-requester
// FIFOs into one tagged ready/valid stream, with an event drain sequencer.
module cba_readout_arbiter #(
  parameter int NREQ      = 4,
  parameter int ROW_BITS  = 10,
  parameter int DATA_BITS = 16
) (
  input logic                   clk,
  input logic                   reset_b,
  cba_readout_arbiter_if.slave  bus
);
  localparam int SRC_BITS = $clog2(NREQ);
  localparam logic [SRC_BITS:0]   NREQ_W   = (SRC_BITS+1)'(NREQ);
  localparam logic [SRC_BITS-1:0] LAST_IDX = SRC_BITS'(NREQ-1);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DONE} state_t;

  state_t                state, state_next;
  logic [ROW_BITS-1:0]   fifo_row  [NREQ][2];
  logic [DATA_BITS-1:0]  fifo_data [NREQ][2];
  logic [1:0]            count [NREQ];
  logic [NREQ-1:0]       wr_ptr, rd_ptr;
  logic [NREQ-1:0]       not_empty, full, pop, accept, drop;
  logic [SRC_BITS-1:0]   rr_ptr, grant;
  logic [SRC_BITS:0]     scan_idx;
  logic                  found, load, quiet, handshake;
  logic                  out_valid;
  logic [ROW_BITS-1:0]   out_row;
  logic [DATA_BITS-1:0]  out_data;
  logic [SRC_BITS-1:0]   out_src;
  logic [NREQ-1:0]       overflow;
  logic [15:0]           word_count;

  assign load      = !out_valid || bus.out_ready;
  assign handshake = out_valid && bus.out_ready;

  always_comb begin
    not_empty = '0;
    full      = '0;
    for (int i = 0; i < NREQ; i++) begin
      not_empty[i] = (count[i] != 2'd0);
      full[i]      = (count[i] == 2'd2);
    end
  end

  // First non-empty FIFO at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SRC_BITS+1)'(k);
      if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
      if (!found && not_empty[scan_idx[SRC_BITS-1:0]]) begin
        found = 1'b1;
        grant = scan_idx[SRC_BITS-1:0];
      end
    end
  end

  // A write into a full FIFO survives only if that FIFO pops in the same cycle.
  always_comb begin
    pop    = '0;
    accept = '0;
    drop   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pop[i]    = load && found && (grant == SRC_BITS'(i));
      accept[i] = bus.in_valid[i] && (!full[i] || pop[i]);
      drop[i]   = bus.in_valid[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        fifo_row[i][wr_ptr[i]]  <= bus.in_row_id[i*ROW_BITS +: ROW_BITS];
        fifo_data[i][wr_ptr[i]] <= bus.in_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
      out_src   <= '0;
      for (int i = 0; i < NREQ; i++) count[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])    rd_ptr[i] <= ~rd_ptr[i];
        count[i] <= count[i] + 2'(accept[i]) - 2'(pop[i]);
        if (drop[i])            overflow[i] <= 1'b1;
        else if (bus.clear_ovf) overflow[i] <= 1'b0;
      end
      if (load) begin
        if (found) begin
          out_valid <= 1'b1;
          out_row   <= fifo_row[grant][rd_ptr[grant]];
          out_data  <= fifo_data[grant][rd_ptr[grant]];
          out_src   <= grant;
          rr_ptr    <= (grant == LAST_IDX) ? '0 : grant + SRC_BITS'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Quiet: adapters idle and nothing left anywhere in the arbiter.
  assign quiet = (bus.busy_in == '0) && (not_empty == '0) && !out_valid;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state      <= IDLE;
      word_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.start)
        word_count <= '0;
      else if ((state == ARM || state == ACTIVE) && handshake && word_count != 16'hFFFF)
        word_count <= word_count + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ARM;
      ARM:     state_next = ACTIVE;
      ACTIVE:  if (quiet) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_row_id = out_row;
  assign bus.out_data   = out_data;
  assign bus.out_src    = out_src;
  assign bus.hold_out   = full;
  assign bus.overflow   = overflow;
  assign bus.active     = (state == ARM) || (state == ACTIVE);
  assign bus.done       = (state == DONE);
  assign bus.word_count = word_count;
endmodule

// File: tb/tb_cba_readout_arbiter.sv
// Directed and randomized checks of cba_readout_arbiter against a queue-style
// reference model of the FIFOs, round-robin grant and event sequence.
module tb_cba_readout_arbiter;
  localparam int NREQ = 4, ROW_BITS = 10, DATA_BITS = 16, SRC_BITS = 2;

  logic clk = 1'b0;
  logic reset_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cba_readout_arbiter_if #(.NREQ(NREQ), .ROW_BITS(ROW_BITS), .DATA_BITS(DATA_BITS)) bus ();

  cba_readout_arbiter #(.NREQ(NREQ), .ROW_BITS(ROW_BITS), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk), .reset_b(reset_b), .bus(bus.slave)
  );

  // Model: FIFO i is an array whose element 0 is the oldest word.
  logic [ROW_BITS-1:0]  m_fifo_row  [NREQ][2];
  logic [DATA_BITS-1:0] m_fifo_data [NREQ][2];
  int                   m_cnt [NREQ];
  int                   m_rr, m_phase, m_wc;
  logic                 m_valid;
  logic [ROW_BITS-1:0]  m_row;
  logic [DATA_BITS-1:0] m_data;
  logic [SRC_BITS-1:0]  m_src;
  logic [NREQ-1:0]      m_ovf;

  task automatic model_step();
    bit load, quiet, hs;
    int g;
    if (!reset_b) begin
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      m_rr = 0; m_phase = 0; m_wc = 0; m_valid = 0;
      m_row = '0; m_data = '0; m_src = '0; m_ovf = '0;
      return;
    end
    load  = !m_valid || bus.out_ready;
    hs    = m_valid && bus.out_ready;
    quiet = (bus.busy_in == '0) && !m_valid;
    for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) quiet = 0;
    if ((m_phase == 1 || m_phase == 2) && hs && m_wc < 65535) m_wc++;
    case (m_phase)
      0: if (bus.start) begin m_phase = 1; m_wc = 0; end
      1: m_phase = 2;
      2: if (quiet) m_phase = 3;
      default: m_phase = 0;
    endcase
    g = -1;
    if (load)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && m_cnt[(m_rr + k) % NREQ] > 0) g = (m_rr + k) % NREQ;
    if (g >= 0) begin
      m_valid = 1; m_row = m_fifo_row[g][0]; m_data = m_fifo_data[g][0];
      m_src = SRC_BITS'(g);
      m_fifo_row[g][0] = m_fifo_row[g][1]; m_fifo_data[g][0] = m_fifo_data[g][1];
      m_cnt[g]--;
      m_rr = (g + 1) % NREQ;
    end else if (load) begin
      m_valid = 0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.clear_ovf) m_ovf[i] = 0;
      if (bus.in_valid[i]) begin
        if (m_cnt[i] < 2) begin
          m_fifo_row[i][m_cnt[i]]  = bus.in_row_id[i*ROW_BITS +: ROW_BITS];
          m_fifo_data[i][m_cnt[i]] = bus.in_data[i*DATA_BITS +: DATA_BITS];
          m_cnt[i]++;
        end else begin
          m_ovf[i] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid  = '0;
    bus.start     = 1'b0;
    bus.clear_ovf = 1'b0;
  endtask

  task automatic put_word(input int r, input logic [ROW_BITS-1:0] row, input logic [DATA_BITS-1:0] data);
    bus.in_valid[r] = 1'b1;
    bus.in_row_id[r*ROW_BITS +: ROW_BITS]   = row;
    bus.in_data[r*DATA_BITS +: DATA_BITS]   = data;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_out got %h want 0", {bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src});
    end
    n_cmp++;
    if ({bus.hold_out, bus.overflow, bus.active, bus.done, bus.word_count} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_status got %h want 0", {bus.hold_out, bus.overflow, bus.active, bus.done, bus.word_count});
    end
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [SRC_BITS-1:0] exp_src [2];
    clear_inputs();
    bus.out_ready = 1'b1;
    put_word(2, 10'h05A, 16'h1234);
    tick();
    clear_inputs();
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src} !== {1'b1, 10'h05A, 16'h1234, 2'd2}) begin
      n_bad++;
      $display("[TB] FAIL single_word got %b/%h/%h/%0d want 1/05a/1234/2",
               bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL single_word_drain got %b want 0", bus.out_valid);
    end
    // rr_ptr now 3, so requester 3 beats requester 0
    exp_src[0] = 2'd3; exp_src[1] = 2'd0;
    put_word(0, 10'h001, 16'h0A00);
    put_word(3, 10'h003, 16'h0A03);
    tick();
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.out_src} !== {1'b1, exp_src[k]}) begin
        n_bad++;
        $display("[TB] FAIL rr_after_single[%0d] got %b/%0d want 1/%0d", k, bus.out_valid, bus.out_src, exp_src[k]);
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    clear_inputs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) put_word(i, ROW_BITS'(10'h100 + i), DATA_BITS'(16'hA000 + i));
    tick();
    clear_inputs();
    for (int i = 0; i < NREQ; i++) begin
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== {1'b1, SRC_BITS'(i), DATA_BITS'(16'hA000 + i)}) begin
        n_bad++;
        $display("[TB] FAIL rr_seq[%0d] got %b/%0d/%h want 1/%0d/%h", i, bus.out_valid, bus.out_src,
                 bus.out_data, i, 16'hA000 + i);
      end
    end
    tick();
    put_word(0, 10'h3FF, 16'hBEEF);
    tick();
    clear_inputs();
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_src, bus.out_row_id, bus.out_data} !== {1'b1, 2'd0, 10'h3FF, 16'hBEEF}) begin
      n_bad++;
      $display("[TB] FAIL rr_next_single got %b/%0d/%h/%h want 1/0/3ff/beef",
               bus.out_valid, bus.out_src, bus.out_row_id, bus.out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_data [2];
    clear_inputs();
    bus.out_ready = 1'b0;
    put_word(0, 10'h011, 16'h1111);
    tick();
    clear_inputs();
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c % 2 == 0) put_word(1, ROW_BITS'(10'h020 + c), DATA_BITS'(16'h2000 + c));
      tick();
      clear_inputs();
      n_cmp++;
      if ({bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src} !== {1'b1, 10'h011, 16'h1111, 2'd0}) begin
        n_bad++;
        $display("[TB] FAIL stall_stable[%0d] got %b/%h/%h/%0d want 1/011/1111/0", c,
                 bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src);
      end
      if (c % 2 == 0) begin
        n_cmp++;
        if ({bus.hold_out[1], bus.overflow[1]} !== {c >= 2, c >= 4}) begin
          n_bad++;
          $display("[TB] FAIL stall_hold_ovf[%0d] got %b%b want %b%b", c, bus.hold_out[1], bus.overflow[1],
                   c >= 2, c >= 4);
        end
      end
    end
    bus.out_ready = 1'b1;
    exp_data[0] = 16'h2000; exp_data[1] = 16'h2002;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== {1'b1, 2'd1, exp_data[k]}) begin
        n_bad++;
        $display("[TB] FAIL stall_release[%0d] got %b/%0d/%h want 1/1/%h", k, bus.out_valid, bus.out_src,
                 bus.out_data, exp_data[k]);
      end
    end
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.hold_out, bus.overflow} !== {1'b0, 4'b0000, 4'b0010}) begin
      n_bad++;
      $display("[TB] FAIL stall_after got %b/%b/%b want 0/0000/0010", bus.out_valid, bus.hold_out, bus.overflow);
    end
    bus.clear_ovf = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (bus.overflow !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL clear_ovf got %b want 0000", bus.overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] exp_data [3];
    clear_inputs();
    bus.out_ready = 1'b0;
    put_word(0, 10'h030, 16'h3000);
    tick();
    clear_inputs();
    tick();
    put_word(0, 10'h031, 16'h3001);
    tick();
    clear_inputs();
    tick();
    put_word(0, 10'h032, 16'h3002);
    tick();
    clear_inputs();
    n_cmp++;
    if (bus.hold_out[0] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL full_hold got %b want 1", bus.hold_out[0]);
    end
    put_word(0, 10'h033, 16'h3003);
    bus.out_ready = 1'b1;
    exp_data[0] = 16'h3001; exp_data[1] = 16'h3002; exp_data[2] = 16'h3003;
    tick();
    clear_inputs();
    n_cmp++;
    if ({bus.hold_out[0], bus.overflow[0]} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL full_pop_status got hold=%b ovf=%b want hold=1 ovf=0", bus.hold_out[0], bus.overflow[0]);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, exp_data[k]}) begin
        n_bad++;
        $display("[TB] FAIL full_pop_order[%0d] got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, exp_data[k]);
      end
    end
    tick();
  endtask

  task automatic test_event();
    int done_seen = 0;
    clear_inputs();
    bus.out_ready = 1'b1;
    bus.busy_in   = '0;
    bus.start     = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if ({bus.active, bus.done, bus.word_count} !== {1'b1, 1'b0, 16'd0}) begin
      n_bad++;
      $display("[TB] FAIL event_arm got %b/%b/%0d want 1/0/0", bus.active, bus.done, bus.word_count);
    end
    bus.busy_in = 4'h3;
    tick();
    for (int w = 0; w < 6; w++) begin
      put_word(w % 2, ROW_BITS'(10'h040 + w), DATA_BITS'(16'h4000 + w));
      if (w == 2) bus.start = 1'b1;
      tick();
      clear_inputs();
      tick();
    end
    tick();
    n_cmp++;
    if ({bus.active, bus.word_count} !== {1'b1, 16'd6}) begin
      n_bad++;
      $display("[TB] FAIL event_midway got %b/%0d want 1/6", bus.active, bus.word_count);
    end
    bus.busy_in = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done === 1'b1) done_seen++;
    end
    n_cmp++;
    if (done_seen != 1) begin
      n_bad++;
      $display("[TB] FAIL event_done_pulses got %0d want 1", done_seen);
    end
    n_cmp++;
    if ({bus.active, bus.word_count} !== {1'b0, 16'd6}) begin
      n_bad++;
      $display("[TB] FAIL event_end got %b/%0d want 0/6", bus.active, bus.word_count);
    end
  endtask

  task automatic test_reset_mid_event();
    clear_inputs();
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    clear_inputs();
    bus.busy_in = 4'h1;
    for (int i = 0; i < NREQ; i++) put_word(i, ROW_BITS'(10'h050 + i), DATA_BITS'(16'h5000 + i));
    tick();
    clear_inputs();
    tick();
    reset_b = 1'b0;
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src, bus.hold_out, bus.overflow,
         bus.active, bus.done, bus.word_count} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_event got v=%b hold=%b act=%b wc=%0d want all 0",
               bus.out_valid, bus.hold_out, bus.active, bus.word_count);
    end
    reset_b = 1'b1;
    bus.busy_in = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.hold_out} !== 5'b0) begin
        n_bad++;
        $display("[TB] FAIL no_stale[%0d] got v=%b hold=%b want 0/0000", c, bus.out_valid, bus.hold_out);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] m_hold;
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    bus.busy_in = '0;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = NREQ'($urandom() & $urandom());
      bus.in_row_id = (NREQ*ROW_BITS)'({$urandom(), $urandom()});
      bus.in_data   = (NREQ*DATA_BITS)'({$urandom(), $urandom()});
      bus.out_ready = ($urandom() % 4) != 0;
      if ($urandom() % 8 == 0) bus.busy_in = ($urandom() % 3 == 0) ? NREQ'($urandom()) : '0;
      bus.start     = ($urandom() % 12) == 0;
      bus.clear_ovf = ($urandom() % 24) == 0;
      tick();
      for (int i = 0; i < NREQ; i++) m_hold[i] = (m_cnt[i] == 2);
      n_cmp++;
      if ({bus.out_valid, bus.out_row_id, bus.out_data, bus.out_src} !== {m_valid, m_row, m_data, m_src}) begin
        n_bad++;
        $display("[TB] FAIL rand_out[%0d] got %b/%h/%h/%0d want %b/%h/%h/%0d", c, bus.out_valid,
                 bus.out_row_id, bus.out_data, bus.out_src, m_valid, m_row, m_data, m_src);
      end
      n_cmp++;
      if ({bus.hold_out, bus.overflow} !== {m_hold, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL rand_fifo[%0d] got hold=%b ovf=%b want hold=%b ovf=%b", c,
                 bus.hold_out, bus.overflow, m_hold, m_ovf);
      end
      n_cmp++;
      if ({bus.active, bus.done, bus.word_count} !== {m_phase == 1 || m_phase == 2, m_phase == 3, 16'(m_wc)}) begin
        n_bad++;
        $display("[TB] FAIL rand_event[%0d] got %b/%b/%0d want %b/%b/%0d", c, bus.active, bus.done,
                 bus.word_count, m_phase == 1 || m_phase == 2, m_phase == 3, m_wc);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset_b       = 1'b0;
    bus.in_valid  = '0;
    bus.in_row_id = '0;
    bus.in_data   = '0;
    bus.busy_in   = '0;
    bus.start     = 1'b0;
    bus.clear_ovf = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_full_pop();
    test_event();
    test_reset_mid_event();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cba_readout_arbiter.md
# cba_readout_arbiter

Round-robin arbiter that merges the hit-row streams of NREQ core-column output adapters into one ready/valid stream toward the data-formatting logic. Each requester gets a 2-entry input FIFO, a source tag on every output word, and a sticky overflow flag. A small event sequencer uses the adapters' Busy lines to report when a readout event has fully drained.

## Interface
- NREQ, 4: number of requesters (2..8).
- ROW_BITS, 10: row identifier width, matching adapter RowIdOut.
- DATA_BITS, 16: data word width, matching adapter DataOut.
- Clk  in  1  clock; all logic on rising edge.
- ResetB  in  1  synchronous, active-low reset.
- InValid  in  NREQ  per-requester word strobe (adapter DataReadyOut).
- InRowId  in  NREQ*ROW_BITS  per-requester row id; requester i in slice [i*ROW_BITS +: ROW_BITS].
- InData  in  NREQ*DATA_BITS  per-requester data; slice [i*DATA_BITS +: DATA_BITS].
- BusyIn  in  NREQ  per-requester Busy.
- Start  in  1  one-cycle pulse that opens an event.
- ClearOvf  in  1  clears all Overflow bits.
- OutValid  out  1  output word valid.
- OutReady  in  1  downstream accept.
- OutRowId  out  ROW_BITS  row id of the output word.
- OutData  out  DATA_BITS  data of the output word.
- OutSrc  out  $clog2(NREQ)  index of the requester that supplied the word.
- HoldOut  out  NREQ  high when requester i's FIFO holds 2 entries.
- Overflow  out  NREQ  sticky: a word was dropped for requester i.
- Active  out  1  event open.
- Done  out  1  one-cycle pulse when an event has drained.
- WordCount  out  16  output handshakes since the last Start; saturates at 0xFFFF.

## Operation
- Reset (ResetB=0 at an edge): all FIFOs empty, rr_ptr=0, output register empty. OutValid=0, OutRowId/OutData/OutSrc=0, HoldOut=0, Overflow=0, Active=0, Done=0, WordCount=0, state IDLE. Reset mid-event discards all buffered words.
- Input FIFO i: depth 2, write on InValid[i].
  - Write when full with no pop in the same cycle: the word is dropped and Overflow[i] sets.
  - Write and pop in the same cycle when full: the write is accepted and count stays 2.
  - Pointers wrap modulo 2.
- Overflow[i] clears only on reset or ClearOvf. If a set and ClearOvf occur in the same cycle, set wins.
- Output register loads when it is empty (OutValid=0) or when OutValid&&OutReady.
  - On load, the arbiter picks the first non-empty FIFO scanning i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - The chosen FIFO pops, and the register captures {row, data, src}.
  - rr_ptr becomes (granted+1) mod NREQ.
  - If no FIFO is non-empty, OutValid drops and rr_ptr is held.
- OutRowId/OutData/OutSrc stay stable while OutValid=1 and OutReady=0.
- WordCount increments on each OutValid&&OutReady while Active=1, saturating at 0xFFFF.
- Event FSM states and transitions:
  - IDLE: Start → ARM, clearing WordCount.
  - ARM: one cycle, so that BusyIn can rise; → ACTIVE.
  - ACTIVE: when quiet → DONE. Quiet means BusyIn=0, all FIFOs empty, and OutValid=0, all in the same cycle.
  - DONE: Done=1 for one cycle; → IDLE.
- Active=1 in ARM and ACTIVE. Start outside IDLE is ignored.
- Arbitration and buffering run independently of the FSM; words arriving in IDLE still pass through but are not counted.

## Timing
- Latency: InValid[i] sampled at edge E (word written into the FIFO). With the output register free and no contention, the word appears on OutValid/OutRowId/OutData/OutSrc after edge E+1.
- Throughput: one word per cycle at the output while OutReady=1. A single requester cannot overflow, because an adapter emits at most one word per 2 cycles.
- HoldOut[i] and Overflow[i] are registered; they update at the edge that changes the FIFO count or drops the word.
- Done asserts at the edge after the first quiet ACTIVE cycle. Earliest: Start at edge S, ARM after S, ACTIVE after S+1, DONE after S+2.

## Test plan
- Single word, no contention: NREQ=4, requester 2 pulses InValid at edge 10 with row 0x05A, data 0x1234, OutReady=1 → after edge 11: OutValid=1, OutRowId=0x05A, OutData=0x1234, OutSrc=2; OutValid=0 after edge 12; rr_ptr=3.
- Round robin under contention: all four requesters present one word at the same edge, rr_ptr=0, OutReady=1 → OutSrc sequence 0,1,2,3 on consecutive cycles; next single word from requester 0 is granted normally.
- Backpressure: OutReady=0 for 5 cycles with one word held → outputs stable, no pop. Requester 1 writes 3 words during the stall → HoldOut[1]=1 after the 2nd word, 3rd word dropped, Overflow[1]=1. OutReady=1 → 2 requester-1 words delivered. ClearOvf → Overflow[1]=0.
- Full with simultaneous pop: FIFO 0 full; at one edge InValid[0]=1 and the arbiter pops FIFO 0 → no overflow, count stays 2, all words delivered in order.
- Event sequence: Start at edge 20, BusyIn=0x3 rising after edge 21, 6 words delivered, BusyIn drops after edge 40 → Done pulses once after all FIFOs and the output register are empty; WordCount=6; Active returns to 0; a second Start during ACTIVE is ignored.
- Reset mid-event: ResetB=0 for one edge while FIFOs hold words and OutValid=1 → all outputs at reset values after that edge; no stale word appears afterwards.
